// File: rtl/shift_register_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package : shift_ctrl_pkg
// Shared types and constants for the shift register controller.
// Rev     : 1.0
// ============================================================================
package shift_ctrl_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int CNT_W_DEF = 3;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
      return (len > width) ? width : len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_register_controller_if.sv
`default_nettype none
// ============================================================================
// Interface : shift_register_controller_if
// Requester and shift-register signals; SHIFT_CTRL_ABORT_EN adds abort/aborted.
// Rev       : 1.0
// ============================================================================
interface shift_register_controller_if
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             req0, req1;
   logic             dir0, dir1;
   logic [WIDTH-1:0] data0, data1;
   logic [CNT_W-1:0] len0, len1;
   logic [WIDTH-1:0] q_in;
   logic             gnt0, gnt1;
   logic             done0, done1;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             sens, sr, sl, shift_en;
`ifdef SHIFT_CTRL_ABORT_EN
   logic             abort;
   logic             aborted;
`endif

   modport master (
      output req0, req1, dir0, dir1, data0, data1, len0, len1, q_in,
      input  gnt0, gnt1, done0, done1, busy, result, sens, sr, sl, shift_en
`ifdef SHIFT_CTRL_ABORT_EN
      , output abort, input aborted
`endif
   );

   modport slave (
      input  req0, req1, dir0, dir1, data0, data1, len0, len1, q_in,
      output gnt0, gnt1, done0, done1, busy, result, sens, sr, sl, shift_en
`ifdef SHIFT_CTRL_ABORT_EN
      , input abort, output aborted
`endif
   );

endinterface
`default_nettype wire

// File: rtl/shift_register_controller_arb.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter_2
// Two-input round-robin arbiter; priority moves to the non-owner on advance.
// Rev    : 1.0
// ============================================================================
module rr_arbiter_2 (
   input  logic clk,
   input  logic rst,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_gnt_valid,
   input  logic i_advance,
   input  logic i_owner,
   output logic o_gnt0,
   output logic o_gnt1
);
   logic r_prio;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prio <= 1'b0;
      end else if (i_advance) begin
         r_prio <= ~i_owner;
      end
   end

   assign o_gnt0 = i_gnt_valid & i_req0 & (~i_req1 | ~r_prio);
   assign o_gnt1 = i_gnt_valid & i_req1 & (~i_req0 |  r_prio);

endmodule
`default_nettype wire

// File: rtl/shift_register_controller.sv
`default_nettype none
// ============================================================================
// Module : shift_register_controller
// Arbitrates two requesters onto one serial-in shift register and sequences
// the shifts. Optional macro SHIFT_CTRL_ABORT_EN adds abort/aborted.
// Rev    : 1.0
// ============================================================================
module shift_register_controller
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
)(
   input logic                        h,
   input logic                        rst,
   shift_register_controller_if.slave bus
);
   state_t           r_state;
   logic             r_owner, r_dir;
   logic             r_gnt0, r_gnt1, r_done0, r_done1, r_busy;
   logic             r_sens, r_sr, r_sl, r_shift_en;
   logic [WIDTH-1:0] r_word, r_result;
   logic [CNT_W-1:0] r_cnt;

   logic             w_win0, w_win1, w_any, w_dir, w_idle, w_adv, w_abort;
   logic [WIDTH-1:0] w_data;
   logic [CNT_W-1:0] w_len_raw, w_len;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_any     = w_win0 | w_win1;
   assign w_dir     = w_win1 ? bus.dir1  : bus.dir0;
   assign w_data    = w_win1 ? bus.data1 : bus.data0;
   assign w_len_raw = w_win1 ? bus.len1  : bus.len0;
   assign w_len     = CNT_W'(clamp_len({{(32-CNT_W){1'b0}}, w_len_raw}, WIDTH));

`ifdef SHIFT_CTRL_ABORT_EN
   logic r_aborted;
   assign w_abort     = bus.abort && (r_state == ST_SHIFT);
   assign bus.aborted = r_aborted;
`else
   assign w_abort = 1'b0;
`endif

   // Priority flips once per transfer, whether it completes or is aborted.
   assign w_adv = (r_state == ST_CAPTURE) || w_abort;

   rr_arbiter_2 u_arb (
      .clk         (h),
      .rst         (rst),
      .i_req0      (bus.req0),
      .i_req1      (bus.req1),
      .i_gnt_valid (w_idle),
      .i_advance   (w_adv),
      .i_owner     (r_owner),
      .o_gnt0      (w_win0),
      .o_gnt1      (w_win1)
   );

   always_ff @(posedge h or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_owner    <= 1'b0;
         r_dir      <= 1'b0;
         r_word     <= '0;
         r_cnt      <= '0;
         r_result   <= '0;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_done0    <= 1'b0;
         r_done1    <= 1'b0;
         r_busy     <= 1'b0;
         r_sens     <= 1'b0;
         r_sr       <= 1'b0;
         r_sl       <= 1'b0;
         r_shift_en <= 1'b0;
`ifdef SHIFT_CTRL_ABORT_EN
         r_aborted  <= 1'b0;
`endif
      end else begin
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
`ifdef SHIFT_CTRL_ABORT_EN
         r_aborted <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_owner <= w_win1;
                  r_dir   <= w_dir;
                  r_gnt0  <= w_win0;
                  r_gnt1  <= w_win1;
                  r_busy  <= 1'b1;
                  r_cnt   <= w_len;
                  if (w_len == '0) begin
                     r_word  <= w_data;
                     r_state <= ST_CAPTURE;
                  end else begin
                     // First bit goes out on the grant edge so shifting starts next cycle.
                     r_state    <= ST_SHIFT;
                     r_shift_en <= 1'b1;
                     r_sens     <= w_dir;
                     r_sr       <= (w_dir == DIR_RIGHT) ? w_data[0]       : 1'b0;
                     r_sl       <= (w_dir == DIR_LEFT)  ? w_data[WIDTH-1] : 1'b0;
                     r_word     <= (w_dir == DIR_LEFT)  ? (w_data << 1)   : (w_data >> 1);
                  end
               end
            end
            ST_SHIFT: begin
               r_cnt <= r_cnt - 1'b1;
               if (w_abort || (r_cnt == CNT_W'(1))) begin
                  r_shift_en <= 1'b0;
                  r_sr       <= 1'b0;
                  r_sl       <= 1'b0;
                  r_state    <= ST_CAPTURE;
`ifdef SHIFT_CTRL_ABORT_EN
                  if (w_abort) begin
                     r_state   <= ST_IDLE;
                     r_busy    <= 1'b0;
                     r_aborted <= 1'b1;
                  end
`endif
               end else begin
                  r_sr   <= (r_dir == DIR_RIGHT) ? r_word[0]       : 1'b0;
                  r_sl   <= (r_dir == DIR_LEFT)  ? r_word[WIDTH-1] : 1'b0;
                  r_word <= (r_dir == DIR_LEFT)  ? (r_word << 1)   : (r_word >> 1);
               end
            end
            ST_CAPTURE: begin
               r_result <= bus.q_in;
               r_done0  <= ~r_owner;
               r_done1  <= r_owner;
               r_state  <= ST_DONE;
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt0     = r_gnt0;
   assign bus.gnt1     = r_gnt1;
   assign bus.done0    = r_done0;
   assign bus.done1    = r_done1;
   assign bus.busy     = r_busy;
   assign bus.result   = r_result;
   assign bus.sens     = r_sens;
   assign bus.sr       = r_sr;
   assign bus.sl       = r_sl;
   assign bus.shift_en = r_shift_en;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_shift_register_controller
// Scoreboard bench with a behavioural shift register on q_in.
// Rev    : 1.0
// ============================================================================
module tb_shift_register_controller;

   logic h = 1'b0;
   logic rst;
   always #5 h = ~h;

   shift_register_controller_if #(.WIDTH(4), .CNT_W(3)) bus ();

   shift_register_controller #(.WIDTH(4), .CNT_W(3)) dut (
      .h   (h),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural register: right shift enters at MSB, left shift enters at LSB.
   logic [3:0] model = 4'b0000;
   always @(posedge h) begin
      if (bus.shift_en) begin
         if (bus.sens) model <= {model[2:0], bus.sl};
         else          model <= {bus.sr, model[3:1]};
      end
   end
   assign bus.q_in = model;

   typedef struct {
      logic       owner;
      logic       dir;
      logic [3:0] result;
      logic [3:0] bits;
      int         nsh;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   g_cyc   = 0;
   int   last_done = 0;
   int   nsh     = 0;
   logic [3:0] bits = '0;
   logic other = 1'b0;
   logic sens_seen = 1'b0;

   always @(posedge h) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: tracks the serial stream and pops the scoreboard on each DONE.
   always @(negedge h) begin
      if (!rst) begin
         if (bus.gnt0 || bus.gnt1) begin
            chk("gnt_onehot", {31'd0, bus.gnt0 & bus.gnt1}, 0);
            chk("busy_at_gnt", {31'd0, bus.busy}, 1);
            g_cyc = cyc; nsh = 0; bits = '0; other = 1'b0;
         end
         if (bus.shift_en) begin
            if (nsh < 4) bits[nsh] = bus.sens ? bus.sl : bus.sr;
            other = other | (bus.sens ? bus.sr : bus.sl);
            sens_seen = bus.sens;
            nsh++;
         end
         if (bus.done0 || bus.done1) begin
            exp_t e;
            last_done = cyc;
            chk("done_onehot", {31'd0, bus.done0 & bus.done1}, 0);
            chk("sb_nonempty", {31'd0, sb.size() > 0}, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("done_owner", {31'd0, bus.done1}, {31'd0, e.owner});
               chk("result", {28'd0, bus.result}, {28'd0, e.result});
               chk("shift_count", nsh, e.nsh);
               chk("serial_bits", {28'd0, bits}, {28'd0, e.bits});
               chk("idle_line_zero", {31'd0, other}, 0);
               chk("latency", cyc - g_cyc, e.nsh + 1);
               chk("busy_at_done", {31'd0, bus.busy}, 1);
               if (e.nsh > 0) chk("sens", {31'd0, sens_seen}, {31'd0, e.dir});
            end
         end
      end
   end

   task automatic xfer(input logic idx, input logic dir, input logic [3:0] data,
                       input logic [2:0] len, input logic [3:0] exp_res,
                       input logic [3:0] exp_bits, input int exp_nsh, input bit push);
      bit seen = 1'b0;
      if (push) sb.push_back('{idx, dir, exp_res, exp_bits, exp_nsh});
      @(negedge h);
      if (idx) begin bus.dir1 = dir; bus.data1 = data; bus.len1 = len; bus.req1 = 1'b1; end
      else     begin bus.dir0 = dir; bus.data0 = data; bus.len0 = len; bus.req0 = 1'b1; end
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge h);
         if (idx ? bus.gnt1 : bus.gnt0) seen = 1'b1;
      end
      chk("gnt_seen", {31'd0, seen}, 1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      if (push) begin
         for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge h);
         chk("done_seen", sb.size(), 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1'b1;
      bus.req0 = 0; bus.req1 = 0; bus.dir0 = 0; bus.dir1 = 0;
      bus.data0 = '0; bus.data1 = '0; bus.len0 = '0; bus.len1 = '0;
`ifdef SHIFT_CTRL_ABORT_EN
      bus.abort = 1'b0;
`endif
      repeat (2) @(negedge h);
      chk("reset_outputs", {19'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy,
                            bus.sens, bus.sr, bus.sl, bus.shift_en, bus.result}, 0);
      rst = 1'b0;

      // Reset in the middle of shifting abandons the transfer.
      xfer(1'b0, 1'b0, 4'b1011, 3'd4, 4'b0, 4'b0, 0, 1'b0);
      @(negedge h);
      chk("shifting_before_reset", {31'd0, bus.shift_en}, 1);
      #2 rst = 1'b1;
      #1 chk("reset_mid_outputs", {19'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy,
                                   bus.sens, bus.sr, bus.sl, bus.shift_en, bus.result}, 0);
      @(negedge h);
      rst = 1'b0;
      repeat (6) @(negedge h);

      xfer(1'b0, 1'b0, 4'b1011, 3'd4, 4'b1011, 4'b1011, 4, 1'b1);
      xfer(1'b1, 1'b1, 4'b0110, 3'd4, 4'b0110, 4'b0110, 4, 1'b1);
      repeat (3) @(negedge h);
      chk("sens_hold", {31'd0, bus.sens}, 1);

      // Both requesters held high out of reset: strict alternation 0,1,0,1.
      @(negedge h);
      rst = 1'b1;
      bus.req0 = 1; bus.dir0 = 0; bus.data0 = 4'b0011; bus.len0 = 3'd4;
      bus.req1 = 1; bus.dir1 = 1; bus.data1 = 4'b1100; bus.len1 = 3'd2;
      sb.push_back('{1'b0, 1'b0, 4'b0011, 4'b0011, 4});
      sb.push_back('{1'b1, 1'b1, 4'b1111, 4'b0011, 2});
      sb.push_back('{1'b0, 1'b0, 4'b0011, 4'b0011, 4});
      sb.push_back('{1'b1, 1'b1, 4'b1111, 4'b0011, 2});
      @(negedge h);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         seen = 1'b0;
         for (int j = 0; j < 30 && !seen; j++) begin
            @(negedge h);
            if (bus.gnt0 || bus.gnt1) seen = 1'b1;
         end
         chk("cont_gnt_seen", {31'd0, seen}, 1);
         chk("cont_gnt_order", {31'd0, bus.gnt1}, k % 2);
         if (k > 0) chk("cont_gap", cyc - last_done, 2);
         if (k == 3) begin bus.req0 = 0; bus.req1 = 0; end
      end
      for (int k = 0; k < 30 && sb.size() > 0; k++) @(negedge h);
      chk("cont_drain", sb.size(), 0);

      // Zero length captures q_in untouched; oversize length clamps to 4.
      xfer(1'b0, 1'b0, 4'b1001, 3'd0, 4'b1111, 4'b0000, 0, 1'b1);
      xfer(1'b0, 1'b0, 4'b0101, 3'd7, 4'b0101, 4'b0101, 4, 1'b1);

`ifdef SHIFT_CTRL_ABORT_EN
      xfer(1'b0, 1'b0, 4'b1110, 3'd4, 4'b0, 4'b0, 0, 1'b0);
      @(negedge h);
      bus.abort = 1'b1;
      @(negedge h);
      bus.abort = 1'b0;
      chk("aborted_pulse", {31'd0, bus.aborted}, 1);
      chk("abort_shift_en", {31'd0, bus.shift_en}, 0);
      chk("abort_result", {28'd0, bus.result}, {28'd0, 4'b0101});
      chk("abort_shifts", nsh, 2);
      repeat (6) @(negedge h);
`endif

      repeat (4) @(negedge h);
      chk("sb_empty_end", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
